lift_req_scheduler: RTL

- Collects hall-call (up/down) and car-call requests for all floors into pending masks.
- Selects the next target floor with a SCAN (elevator) policy and hands it to the lift controller over a valid/ready handshake.
- Clears served requests when the lift reports arrival.
- Sits between the floor/car button logic and the lift motion/door controller.

---
 rtl/lift_req_scheduler_if.sv | 29 ++
 rtl/lift_req_scheduler.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/lift_req_scheduler_if.sv
// Target handshake between the request scheduler and the lift motion/door
// controller.
//   i_cur_floor  : current lift floor (controller -> scheduler)
//   i_arrived    : one-cycle pulse, lift stopped and door cycle complete
//   i_tgt_ready  : controller accepts the offered target
//   o_tgt_valid  : target offered (scheduler -> controller)
//   o_tgt_floor  : offered target floor
//   o_dir        : sweep direction, 1 = up, 0 = down
// master = scheduler side, slave = lift controller side.
interface lift_req_scheduler_if #(
    parameter int unsigned FLOOR_W = 5
);
    logic [FLOOR_W-1:0] i_cur_floor;
    logic               i_arrived;
    logic               i_tgt_ready;
    logic               o_tgt_valid;
    logic [FLOOR_W-1:0] o_tgt_floor;
    logic               o_dir;

    modport master (
        input  i_cur_floor, i_arrived, i_tgt_ready,
        output o_tgt_valid, o_tgt_floor, o_dir
    );

    modport slave (
        output i_cur_floor, i_arrived, i_tgt_ready,
        input  o_tgt_valid, o_tgt_floor, o_dir
    );
endinterface

// File: rtl/lift_req_scheduler.sv
// Lift request scheduler: collects hall-up, hall-down and car-panel calls
// into pending masks, picks the next target floor with a SCAN sweep policy
// and offers it to the lift controller over a valid/ready handshake. Served
// requests are cleared when the lift reports arrival.
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_hall_up    : up-call pulses, one bit per floor
//   i_hall_dn    : down-call pulses, one bit per floor
//   i_car        : car-panel call pulses, one bit per floor
//   o_pending    : OR of the three pending masks
//   o_busy       : high whenever the scheduler is not idle
//   bus          : target handshake to the lift controller (master side)
module lift_req_scheduler #(
    parameter int unsigned NUM_FLOORS = 32,
    parameter int unsigned FLOOR_W    = 5
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_FLOORS-1:0] i_hall_up,
    input  logic [NUM_FLOORS-1:0] i_hall_dn,
    input  logic [NUM_FLOORS-1:0] i_car,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_busy,
    lift_req_scheduler_if.master  bus
);

    typedef enum logic [1:0] {IDLE, SCAN, ISSUE, TRAVEL} state_t;

    state_t                state, state_nxt;
    logic [NUM_FLOORS-1:0] pend_up, pend_dn, pend_car;
    logic [NUM_FLOORS-1:0] pending, clr;
    logic [FLOOR_W-1:0]    tgt_floor, tgt_nxt;
    logic                  dir, dir_nxt;
    int unsigned           cur_idx, above_idx, below_idx;
    logic                  hit_cur, any_above, any_below;

    assign pending = pend_up | pend_dn | pend_car;

    // Out-of-range floor reports are treated as the top floor.
    always_comb begin
        cur_idx = 32'(bus.i_cur_floor);
        if (cur_idx >= NUM_FLOORS) begin
            cur_idx = NUM_FLOORS - 1;
        end
    end

    // One pass over the floors yields: the hit at the current floor, the
    // nearest pending floor above (first found ascending) and the nearest
    // below (last found ascending), plus the arrival clear mask.
    always_comb begin
        hit_cur   = 1'b0;
        any_above = 1'b0;
        any_below = 1'b0;
        above_idx = 0;
        below_idx = 0;
        clr       = '0;
        for (int unsigned k = 0; k < NUM_FLOORS; k++) begin
            if (k == cur_idx) begin
                hit_cur = pending[k];
                clr[k]  = (state == TRAVEL) && bus.i_arrived;
            end else if (pending[k]) begin
                if (k > cur_idx) begin
                    if (!any_above) begin
                        any_above = 1'b1;
                        above_idx = k;
                    end
                end else begin
                    any_below = 1'b1;
                    below_idx = k;
                end
            end
        end
    end

    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_floor;
        dir_nxt   = dir;
        case (state)
            IDLE: begin
                if (pending != '0) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (pending == '0) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = ISSUE;
                    if (hit_cur) begin
                        tgt_nxt = FLOOR_W'(cur_idx);
                    end else if (dir) begin
                        if (any_above) begin
                            tgt_nxt = FLOOR_W'(above_idx);
                        end else begin
                            tgt_nxt = FLOOR_W'(below_idx);
                            dir_nxt = 1'b0;
                        end
                    end else begin
                        if (any_below) begin
                            tgt_nxt = FLOOR_W'(below_idx);
                        end else begin
                            tgt_nxt = FLOOR_W'(above_idx);
                            dir_nxt = 1'b1;
                        end
                    end
                end
            end
            ISSUE: begin
                if (bus.i_tgt_ready) begin
                    state_nxt = TRAVEL;
                end
            end
            TRAVEL: begin
                if (bus.i_arrived) begin
                    state_nxt = SCAN;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= IDLE;
            pend_up   <= '0;
            pend_dn   <= '0;
            pend_car  <= '0;
            tgt_floor <= '0;
            dir       <= 1'b1;
        end else begin
            state     <= state_nxt;
            // A new call at the arrival floor in the arrival cycle is served
            // by that arrival, so clear wins over set.
            pend_up   <= (pend_up  | i_hall_up) & ~clr;
            pend_dn   <= (pend_dn  | i_hall_dn) & ~clr;
            pend_car  <= (pend_car | i_car)     & ~clr;
            tgt_floor <= tgt_nxt;
            dir       <= dir_nxt;
        end
    end

    assign o_pending       = pending;
    assign o_busy          = (state != IDLE);
    assign bus.o_tgt_valid = (state == ISSUE);
    assign bus.o_tgt_floor = tgt_floor;
    assign bus.o_dir       = dir;

endmodule
